// File: rtl/a2d_pkg.sv
// a2d_pkg: shared definitions for the A2D conversion scheduler.
//   - channel codes carried in cmd[13:11]
//   - FSM state encoding
//   - slot2chan(): schedule slot -> channel code
//   - chan2onehot(): channel code -> position in the {torque,brake,curr,batt} set
package a2d_pkg;

    localparam logic [2:0] CH_BATT   = 3'd0;
    localparam logic [2:0] CH_CURR   = 3'd1;
    localparam logic [2:0] CH_BRAKE  = 3'd3;
    localparam logic [2:0] CH_TORQUE = 3'd4;

    localparam int N_CHAN    = 4;
    localparam int BRAKE_IDX = 2;   // brake position in the per-channel register set

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WAIT1,
        ST_GAP,
        ST_READ,
        ST_WAIT2,
        ST_STORE
    } state_t;

    // Interleaved schedule puts brake on every even slot (brake,batt,brake,curr,brake,torque);
    // the plain schedule is a straight 4-slot rotation.
    function automatic logic [2:0] slot2chan(input logic [2:0] slot, input logic intlv);
        logic [2:0] ch;
        ch = CH_BRAKE;
        if (intlv) begin
            case (slot)
                3'd1:    ch = CH_BATT;
                3'd3:    ch = CH_CURR;
                3'd5:    ch = CH_TORQUE;
                default: ch = CH_BRAKE;
            endcase
        end else begin
            case (slot)
                3'd0:    ch = CH_BATT;
                3'd1:    ch = CH_CURR;
                3'd2:    ch = CH_BRAKE;
                3'd3:    ch = CH_TORQUE;
                default: ch = CH_BATT;
            endcase
        end
        return ch;
    endfunction

    function automatic logic [N_CHAN-1:0] chan2onehot(input logic [2:0] chan);
        logic [N_CHAN-1:0] oh;
        oh = '0;
        case (chan)
            CH_BATT:   oh = 4'b0001;
            CH_CURR:   oh = 4'b0010;
            CH_BRAKE:  oh = 4'b0100;
            CH_TORQUE: oh = 4'b1000;
            default:   oh = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/a2d_scheduler_if.sv
// a2d_scheduler_if: request/response link between the scheduler and the SPI master.
//   snd  : one-cycle start pulse (scheduler -> SPI master)
//   cmd  : 16-bit command word  (scheduler -> SPI master)
//   done : one-cycle completion pulse (SPI master -> scheduler)
//   resp : 16-bit response word, valid with done (SPI master -> scheduler)
interface a2d_scheduler_if;
    logic        snd;
    logic [15:0] cmd;
    logic        done;
    logic [15:0] resp;

    modport master (output snd, output cmd, input done, input resp);
    modport slave  (input snd, input cmd, output done, output resp);
endinterface

// File: rtl/a2d_scheduler.sv
// a2d_scheduler: paced sequencer for the shared 4-channel A2D SPI path.
// Each conversion sends the channel command twice (the first reply is stale
// and discarded), then latches the second reply into the slot's channel register.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   spi (master)      : snd/cmd out, done/resp in
//   batt/curr/brake/torque : latest 12-bit readings
//   upd               : one-cycle one-hot update strobe {torque,brake,curr,batt}
//   brake_n           : registered, 0 while brake < 12'h800
//   err               : sticky transaction-timeout flag
module a2d_scheduler
    import a2d_pkg::*;
#(
    parameter int FAST_SIM   = 0,
    parameter int PERIOD     = 4096,
    parameter int PERIOD_SIM = 64,
    parameter int BRK_INTLV  = 1,
    parameter int TMO_CYC    = 1023
) (
    input  logic                clk,
    input  logic                rst,
    a2d_scheduler_if.master     spi,
    output logic [11:0]         batt,
    output logic [11:0]         curr,
    output logic [11:0]         brake,
    output logic [11:0]         torque,
    output logic [N_CHAN-1:0]   upd,
    output logic                brake_n,
    output logic                err
);

    localparam int               P         = (FAST_SIM != 0) ? PERIOD_SIM : PERIOD;
    localparam int               IV_W      = $clog2(P) + 1;
    localparam logic [IV_W-1:0]  IV_TERM   = IV_W'(P - 1);
    localparam int               WT_W      = $clog2(TMO_CYC) + 1;
    localparam logic [WT_W-1:0]  WT_TERM   = WT_W'(TMO_CYC - 1);
    localparam logic             INTLV     = (BRK_INTLV != 0);
    localparam logic [2:0]       SLOT_LAST = INTLV ? 3'd5 : 3'd3;

    state_t             r_state, w_state_next;
    logic [IV_W-1:0]    r_iv_cnt, w_iv_next;
    logic [WT_W-1:0]    r_wt_cnt, w_wt_next;
    logic [2:0]         r_slot, w_slot_next, w_slot_adv;
    logic [15:0]        r_cmd, w_cmd_next;
    logic [11:0]        r_hold, w_hold_next;
    logic [11:0]        r_chan [N_CHAN];
    logic [N_CHAN-1:0]  r_upd, w_upd_sel, w_ch_we;
    logic               r_brake_n, r_err;
    logic               w_store, w_tmo;

    assign w_slot_adv = (r_slot == SLOT_LAST) ? 3'd0 : r_slot + 3'd1;
    assign w_upd_sel  = chan2onehot(r_cmd[13:11]);

    // Next-state / datapath decode
    always_comb begin
        w_state_next = r_state;
        w_iv_next    = r_iv_cnt;
        w_wt_next    = r_wt_cnt;
        w_slot_next  = r_slot;
        w_cmd_next   = r_cmd;
        w_hold_next  = r_hold;
        w_store      = 1'b0;
        w_tmo        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_iv_cnt == IV_TERM) begin
                    w_state_next = ST_CMD;
                    w_iv_next    = '0;
                    w_cmd_next   = {2'b00, slot2chan(r_slot, INTLV), 11'h000};
                end else begin
                    w_iv_next = r_iv_cnt + 1'b1;
                end
            end
            ST_CMD: begin
                w_state_next = ST_WAIT1;
                w_wt_next    = '0;
            end
            ST_WAIT1, ST_WAIT2: begin
                // done has priority over an expiring wait counter
                if (spi.done) begin
                    if (r_state == ST_WAIT2) begin
                        w_hold_next  = spi.resp[11:0];
                        w_state_next = ST_STORE;
                    end else begin
                        w_state_next = ST_GAP;
                    end
                end else if (r_wt_cnt == WT_TERM) begin
                    w_tmo        = 1'b1;
                    w_slot_next  = w_slot_adv;
                    w_state_next = ST_IDLE;
                end else begin
                    w_wt_next = r_wt_cnt + 1'b1;
                end
            end
            ST_GAP:  w_state_next = ST_READ;    // lets SS_n deassert between frames
            ST_READ: begin
                w_state_next = ST_WAIT2;
                w_wt_next    = '0;
            end
            ST_STORE: begin
                w_store      = 1'b1;
                w_slot_next  = w_slot_adv;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    // Counters, slot pointer, command and holding registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_iv_cnt <= '0;
            r_wt_cnt <= '0;
            r_slot   <= '0;
            r_cmd    <= '0;
            r_hold   <= '0;
            r_err    <= 1'b0;
        end else begin
            r_iv_cnt <= w_iv_next;
            r_wt_cnt <= w_wt_next;
            r_slot   <= w_slot_next;
            r_cmd    <= w_cmd_next;
            r_hold   <= w_hold_next;
            r_err    <= r_err | w_tmo;
        end
    end

    for (genvar gi = 0; gi < N_CHAN; gi++) begin : g_we
        assign w_ch_we[gi] = w_store & w_upd_sel[gi];
    end

    // Channel registers, update strobe and derived brake_n
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CHAN; i++) r_chan[i] <= '0;
            r_upd     <= '0;
            r_brake_n <= 1'b0;
        end else begin
            for (int i = 0; i < N_CHAN; i++) begin
                if (w_ch_we[i]) r_chan[i] <= r_hold;
            end
            r_upd     <= w_ch_we;
            r_brake_n <= (r_chan[BRAKE_IDX] >= 12'h800);
        end
    end

    assign spi.snd = (r_state == ST_CMD) || (r_state == ST_READ);
    assign spi.cmd = r_cmd;
    assign batt    = r_chan[0];
    assign curr    = r_chan[1];
    assign brake   = r_chan[2];
    assign torque  = r_chan[3];
    assign upd     = r_upd;
    assign brake_n = r_brake_n;
    assign err     = r_err;

endmodule
